// File: rtl/fetch_unpacker.sv
// Fetch packet unpacker: holds one fetch packet and feeds decode one
// instruction per cycle, popping the next packet as the last slot leaves.
//
// state | meaning
// EMPTY | no instruction held, pop whenever the FIFO allows
// LO    | only slot 0 remains (packet loaded with mask 01)
// HI    | only slot 1 remains (slot 0 accepted, or mask 10 loaded)
// BOTH  | both slots remain, slot 0 presented first
//
// The state encoding is the remaining-slot mask itself, so a popped packet's
// mask field loads straight into the state register.
module fetch_unpacker #(
   parameter int kInstWidth = 32,
   parameter int kAddrWidth = 32,
   parameter int kPktWidth  = 2*kInstWidth + kAddrWidth + 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_is_empty,
   input  logic                  fifo_write_en,
   input  logic [kPktWidth-1:0]  fifo_read_data,
   output logic                  fifo_read_en,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [kAddrWidth-1:0] dec_pc,
   output logic [kInstWidth-1:0] dec_inst,
   output logic                  dec_last
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      LO    = 2'b01,
      HI    = 2'b10,
      BOTH  = 2'b11
   } state_t;

   state_t                  state_q, state_d;
   logic [kAddrWidth-1:0]   pc_q;
   logic [kInstWidth-1:0]   inst0_q, inst1_q;
   logic                    load;
   logic                    slot_hi;
   logic                    accept;
   logic                    drain;

   // packet field extraction: {pc, inst1, inst0, mask}
   logic [1:0]              pkt_mask;
   logic [kInstWidth-1:0]   pkt_inst0, pkt_inst1;
   logic [kAddrWidth-1:0]   pkt_pc;

   assign pkt_mask  = fifo_read_data[1:0];
   assign pkt_inst0 = fifo_read_data[2 +: kInstWidth];
   assign pkt_inst1 = fifo_read_data[2+kInstWidth +: kInstWidth];
   assign pkt_pc    = fifo_read_data[2+2*kInstWidth +: kAddrWidth];

   // Slot 1 is presented only when slot 0 is no longer pending.
   assign slot_hi   = (state_q == HI);
   assign dec_valid = (state_q != EMPTY) && !flush;
   assign dec_last  = dec_valid && ((state_q == LO) || (state_q == HI));
   assign dec_inst  = slot_hi ? inst1_q : inst0_q;
   assign dec_pc    = pc_q + (slot_hi ? kAddrWidth'(4) : kAddrWidth'(0));

   assign accept    = dec_valid && dec_ready;
   assign drain     = (state_q == EMPTY) || (accept && dec_last);
   // The FIFO drops reads in its write cycles, so never pop alongside a write.
   // Gating with rst keeps the FIFO untouched while the block is held in reset.
   assign fifo_read_en = drain && !fifo_is_empty && !fifo_write_en && !flush && rst;

   // Next-state: flush beats pop, pop beats the accept-clear.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else if (fifo_read_en) begin
         state_d = state_t'(pkt_mask);
         load    = 1'b1;
      end else if (accept) begin
         case (state_q)
            BOTH:    state_d = HI;
            LO:      state_d = EMPTY;
            HI:      state_d = EMPTY;
            default: state_d = EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Holding register payload, written only on a pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= '0;
         inst0_q <= '0;
         inst1_q <= '0;
      end else if (load) begin
         pc_q    <= pkt_pc;
         inst0_q <= pkt_inst0;
         inst1_q <= pkt_inst1;
      end
   end

endmodule

// File: tb/tb_fetch_unpacker.sv
// Directed bench for fetch_unpacker: a behavioural fetch FIFO feeds the DUT,
// stimulus queues the expected decode beats, and a monitor checks each
// accepted beat against that queue.
module tb_fetch_unpacker;

   localparam int kIW = 32;
   localparam int kAW = 32;
   localparam int kPW = 2*kIW + kAW + 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            fifo_is_empty;
   logic            fifo_write_en;
   logic [kPW-1:0]  fifo_read_data;
   logic            fifo_read_en;
   logic            dec_valid;
   logic            dec_ready;
   logic [kAW-1:0]  dec_pc;
   logic [kIW-1:0]  dec_inst;
   logic            dec_last;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        last;
   } beat_t;

   beat_t exp_q[$];

   // behavioural fetch FIFO
   logic [kPW-1:0] mem [0:63];
   logic [6:0]     rd_ptr = '0;
   logic [6:0]     wr_ptr = '0;

   assign fifo_is_empty  = (rd_ptr == wr_ptr);
   assign fifo_read_data = mem[rd_ptr[5:0]];

   always #5 clk = ~clk;

   // FIFO pop on the DUT's read strobe
   always @(posedge clk) begin
      if (fifo_read_en) rd_ptr <= rd_ptr + 7'd1;
   end

   fetch_unpacker dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .fifo_is_empty  (fifo_is_empty),
      .fifo_write_en  (fifo_write_en),
      .fifo_read_data (fifo_read_data),
      .fifo_read_en   (fifo_read_en),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_pc         (dec_pc),
      .dec_inst       (dec_inst),
      .dec_last       (dec_last)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] i1,
                       input logic [31:0] i0, input logic [1:0] m);
      beat_t b;
      mem[wr_ptr[5:0]] = {pc, i1, i0, m};
      wr_ptr = wr_ptr + 7'd1;
      if (m == 2'b11) begin
         b.pc = pc;      b.inst = i0; b.last = 1'b0; exp_q.push_back(b);
         b.pc = pc + 4;  b.inst = i1; b.last = 1'b1; exp_q.push_back(b);
      end else if (m == 2'b01) begin
         b.pc = pc;      b.inst = i0; b.last = 1'b1; exp_q.push_back(b);
      end else if (m == 2'b10) begin
         b.pc = pc + 4;  b.inst = i1; b.last = 1'b1; exp_q.push_back(b);
      end
   endtask

   // monitor: every accepted beat must match the head of the expected queue
   always @(negedge clk) begin
      if (rst && dec_valid && dec_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got pc %h inst %h want none", dec_pc, dec_inst);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("mon_pc",   dec_pc,          e.pc);
            check("mon_inst", dec_inst,        e.inst);
            check("mon_last", 32'(dec_last),   32'(e.last));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      fifo_write_en = 1'b0;
      dec_ready = 1'b0;
      tick();
      tick();
      check("rst_valid",   32'(dec_valid),    32'd0);
      check("rst_last",    32'(dec_last),     32'd0);
      check("rst_rden",    32'(fifo_read_en), 32'd0);
      check("rst_pc",      dec_pc,            32'd0);
      check("rst_inst",    dec_inst,          32'd0);
      rst = 1'b1;
      tick();

      // basic drain, two full packets back to back
      dec_ready = 1'b1;
      push(32'h1000, 32'hB, 32'hA, 2'b11);
      push(32'h1008, 32'hD, 32'hC, 2'b11);
      #1;
      check("t1_pop_empty", 32'(fifo_read_en), 32'd1);
      check("t1_valid_n",   32'(dec_valid),    32'd0);
      tick();
      check("t1_valid0",    32'(dec_valid),    32'd1);
      check("t1_pc0",       dec_pc,            32'h1000);
      check("t1_rden0",     32'(fifo_read_en), 32'd0);
      tick();
      check("t1_pc1",       dec_pc,            32'h1004);
      check("t1_last1",     32'(dec_last),     32'd1);
      check("t1_rden1",     32'(fifo_read_en), 32'd1);
      tick();
      check("t1_pc2",       dec_pc,            32'h1008);
      check("t1_valid2",    32'(dec_valid),    32'd1);
      check("t1_rden2",     32'(fifo_read_en), 32'd0);
      tick();
      check("t1_pc3",       dec_pc,            32'h100C);
      check("t1_rden3",     32'(fifo_read_en), 32'd0);
      tick();
      check("t1_idle",      32'(dec_valid),    32'd0);

      // HI-only packet
      push(32'h2000, 32'hE1, 32'hE0, 2'b10);
      tick();
      check("t2_hi_pc",     dec_pc,            32'h2004);
      check("t2_hi_inst",   dec_inst,          32'hE1);
      check("t2_hi_last",   32'(dec_last),     32'd1);
      tick();
      check("t2_hi_idle",   32'(dec_valid),    32'd0);

      // empty-mask packet is discarded, next packet two cycles after its pop
      push(32'h3000, 32'h31, 32'h30, 2'b00);
      push(32'h3008, 32'hF1, 32'hF0, 2'b11);
      #1;
      check("t3_pop00",     32'(fifo_read_en), 32'd1);
      tick();
      check("t3_gap_valid", 32'(dec_valid),    32'd0);
      check("t3_gap_rden",  32'(fifo_read_en), 32'd1);
      tick();
      check("t3_valid",     32'(dec_valid),    32'd1);
      check("t3_pc",        dec_pc,            32'h3008);
      tick();
      tick();

      // backpressure while BOTH
      dec_ready = 1'b0;
      push(32'h4000, 32'h41, 32'h40, 2'b11);
      push(32'h4008, 32'h43, 32'h42, 2'b11);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_stall_pc",   dec_pc,            32'h4000);
         check("t4_stall_inst", dec_inst,          32'h40);
         check("t4_stall_rden", 32'(fifo_read_en), 32'd0);
         tick();
      end
      dec_ready = 1'b1;
      #1;
      check("t4_rel_rden",  32'(fifo_read_en), 32'd0);
      tick();
      check("t4_pc1",       dec_pc,            32'h4004);
      check("t4_rden1",     32'(fifo_read_en), 32'd1);
      tick();
      check("t4_nobubble",  32'(dec_valid),    32'd1);
      check("t4_pc2",       dec_pc,            32'h4008);
      tick();
      tick();

      // flush while HI with a non-empty FIFO
      push(32'h5000, 32'h51, 32'h50, 2'b11);
      push(32'h5008, 32'h53, 32'h52, 2'b11);
      tick();
      tick();
      check("t5_pre_pc",    dec_pc,            32'h5004);
      void'(exp_q.pop_front());
      flush = 1'b1;
      #1;
      check("t5_fl_valid",  32'(dec_valid),    32'd0);
      check("t5_fl_rden",   32'(fifo_read_en), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("t5_empty_val", 32'(dec_valid),    32'd0);
      check("t5_empty_rd",  32'(fifo_read_en), 32'd1);
      tick();
      check("t5_pc",        dec_pc,            32'h5008);
      tick();
      tick();

      // write collision during a drain cycle
      push(32'h6000, 32'h61, 32'h60, 2'b11);
      tick();
      tick();
      fifo_write_en = 1'b1;
      push(32'h6008, 32'h63, 32'h62, 2'b11);
      #1;
      check("t6_col_rden",  32'(fifo_read_en), 32'd0);
      check("t6_col_valid", 32'(dec_valid),    32'd1);
      tick();
      push(32'h6010, 32'h65, 32'h64, 2'b01);
      #1;
      check("t6_gap_valid", 32'(dec_valid),    32'd0);
      check("t6_gap_rden",  32'(fifo_read_en), 32'd0);
      tick();
      fifo_write_en = 1'b0;
      #1;
      check("t6_pop_rden",  32'(fifo_read_en), 32'd1);
      tick();
      check("t6_pc",        dec_pc,            32'h6008);
      tick();
      tick();
      check("t6_lo_pc",     dec_pc,            32'h6010);
      tick();

      // reset in the middle of a held packet
      dec_ready = 1'b0;
      push(32'h7000, 32'h71, 32'h70, 2'b11);
      tick();
      check("t7_pre_valid", 32'(dec_valid),    32'd1);
      rst = 1'b0;
      #1;
      check("t7_valid",     32'(dec_valid),    32'd0);
      check("t7_rden",      32'(fifo_read_en), 32'd0);
      check("t7_pc",        dec_pc,            32'd0);
      check("t7_inst",      dec_inst,          32'd0);
      exp_q.delete();
      tick();
      push(32'h8000, 32'h81, 32'h80, 2'b11);
      #1;
      check("t7_hold_rden", 32'(fifo_read_en), 32'd0);
      tick();
      rst = 1'b1;
      dec_ready = 1'b1;
      #1;
      check("t7_rel_rden",  32'(fifo_read_en), 32'd1);
      tick();
      check("t7_pc0",       dec_pc,            32'h8000);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("leftover_beats", 32'(exp_q.size()), 32'd0);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
